serial_addsub_ctrl: RTL and testbench

Sequencing controller that performs wide (NIBBLES×4-bit) addition/subtraction by time-multiplexing one 4-bit adder-subtractor nibble slice over consecutive clock cycles, LSB nibble first, with a registered carry/borrow chain. Sits between a requesting master (start/done handshake) and the shared 4-bit full-adder datapath. Mode and carry semantics match the team's combinational 4-bit adder-subtractor: Mode=0 add, Mode=1 two's-complement subtract (B inverted, initial carry-in=1).

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/nibble_addsub.sv | 29 ++
 rtl/serial_addsub_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared FSM state encoding and mode constants for the serial adder-subtractor controller.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple adder-subtractor slice; mode=1 inverts b.
// c3 is the carry into bit 3, used for signed overflow detection.
module nibble_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] bx;
    logic [4:0] c;

    always_comb begin
        bx   = b ^ {4{mode}};
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
        cout = c[4];
        c3   = c[3];
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Wide add/subtract by time-multiplexing one nibble slice, LSB nibble first.
// Optional signed overflow output OVF is enabled by defining OVERFLOW_FLAG_EN.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   Mode,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   D_S,
`ifdef OVERFLOW_FLAG_EN
    output logic                   OVF,
`endif
    output logic                   B_C
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state, next_state;
    logic [W-1:0]    a_reg, b_reg;
    logic            mode_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            accept, step, last;
    logic [3:0]      a_nib, b_nib, s_nib;
    logic            c_out;
`ifdef OVERFLOW_FLAG_EN
    logic            c_msb_in;
`else
    logic            slice_c3_unused;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last       = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[i*4 +: 4];
                b_nib = b_reg[i*4 +: 4];
            end
        end
    end

    nibble_addsub u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .mode (mode_reg),
        .cin  (carry),
        .s    (s_nib),
        .cout (c_out),
`ifdef OVERFLOW_FLAG_EN
        .c3   (c_msb_in)
`else
        .c3   (slice_c3_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= MODE_ADD;
            carry    <= 1'b0;
            idx      <= '0;
            D_S      <= '0;
            B_C      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            OVF      <= 1'b0;
`endif
        end else if (accept) begin
            a_reg    <= A;
            b_reg    <= B;
            mode_reg <= Mode;
            carry    <= Mode;  // subtract seeds the chain with +1
            idx      <= '0;
            D_S      <= '0;
            B_C      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            OVF      <= 1'b0;
`endif
        end else if (step) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) D_S[i*4 +: 4] <= s_nib;
            end
            carry <= c_out;
            if (last) begin
                idx <= '0;
                B_C <= c_out;
`ifdef OVERFLOW_FLAG_EN
                OVF <= c_out ^ c_msb_in;
`endif
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at NIBBLES=4 (16-bit operands).
module tb_serial_addsub_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         Mode;
    logic [W-1:0] A, B;
    logic         ready, busy, done, B_C;
    logic [W-1:0] D_S;
`ifdef OVERFLOW_FLAG_EN
    logic         OVF;
`endif

    int total = 0;
    int bad   = 0;

    serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Mode  (Mode),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .D_S   (D_S),
`ifdef OVERFLOW_FLAG_EN
        .OVF   (OVF),
`endif
        .B_C   (B_C)
    );

    always #5 clk = ~clk;

    // Drive one operation and return cycles from accepting edge to done (0 = timeout).
    task automatic do_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        @(negedge clk);
        Mode  = m;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; Mode = 1'b0; A = '0; B = '0;
        #2;
        total++;
        if ({ready, busy, done, B_C} !== 4'b1000 || D_S !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: got rdy/busy/done/bc=%b D_S=%h, want 1000 D_S=0000",
                     {ready, busy, done, B_C}, D_S);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        do_op(1'b0, 16'h1234, 16'h0FFF, lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", lat); end
        total++;
        if (D_S !== 16'h2233 || B_C !== 1'b0) begin
            bad++; $display("FAIL add_basic: got %h/%b want 2233/0", D_S, B_C);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || ready !== 1'b1 || D_S !== 16'h2233) begin
            bad++; $display("FAIL add_hold: got done=%b ready=%b D_S=%h want 0/1/2233", done, ready, D_S);
        end
        do_op(1'b0, 16'hFFFF, 16'h0001, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h0000 || B_C !== 1'b1) begin
            bad++; $display("FAIL add_carry1: got lat=%0d %h/%b want 4 0000/1", lat, D_S, B_C);
        end
        do_op(1'b0, 16'hFFFF, 16'hFFFF, lat);
        total++;
        if (lat !== 4 || D_S !== 16'hFFFE || B_C !== 1'b1) begin
            bad++; $display("FAIL add_carry2: got lat=%0d %h/%b want 4 FFFE/1", lat, D_S, B_C);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_op(1'b1, 16'h1000, 16'h0001, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h0FFF || B_C !== 1'b1) begin
            bad++; $display("FAIL sub_borrow_chain: got lat=%0d %h/%b want 4 0FFF/1", lat, D_S, B_C);
        end
        do_op(1'b1, 16'h0003, 16'h0005, lat);
        total++;
        if (lat !== 4 || D_S !== 16'hFFFE || B_C !== 1'b0) begin
            bad++; $display("FAIL sub_negative: got lat=%0d %h/%b want 4 FFFE/0", lat, D_S, B_C);
        end
        do_op(1'b1, 16'h8888, 16'h8888, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h0000 || B_C !== 1'b1) begin
            bad++; $display("FAIL sub_equal: got lat=%0d %h/%b want 4 0000/1", lat, D_S, B_C);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        Mode = 1'b0; A = 16'h1234; B = 16'h0FFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++; $display("FAIL busy_flags: got busy=%b ready=%b want 1/0", busy, ready);
        end
        @(negedge clk);
        start = 1'b1; Mode = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; A = 16'hAAAA; B = 16'h5555;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = i; break; end
        end
        total++;
        if (lat !== 2 || D_S !== 16'h2233 || B_C !== 1'b0) begin
            bad++; $display("FAIL ignore_busy: got lat=%0d %h/%b want 2 2233/0", lat, D_S, B_C);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL ignore_busy_idle: got busy=%b ready=%b want 0/1", busy, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0]  seen;
        logic [W-1:0] r1, r2;
        logic         c1, c2;
        seen = '0; r1 = '0; r2 = '0; c1 = 1'b0; c2 = 1'b0;
        @(negedge clk);
        Mode = 1'b0; A = 16'h0001; B = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 Mode = 1'b1; A = 16'h0010; B = 16'h0001;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            seen[i] = done;
            if (i == 4) begin r1 = D_S; c1 = B_C; end
            if (i == 9) begin r2 = D_S; c2 = B_C; start = 1'b0; end
        end
        total++;
        if (seen[10:1] !== 10'b01_0000_1000) begin
            bad++; $display("FAIL b2b_done_pattern: got %b want 0100001000", seen[10:1]);
        end
        total++;
        if (r1 !== 16'h0003 || c1 !== 1'b0) begin
            bad++; $display("FAIL b2b_first: got %h/%b want 0003/0", r1, c1);
        end
        total++;
        if (r2 !== 16'h000F || c2 !== 1'b1) begin
            bad++; $display("FAIL b2b_second: got %h/%b want 000F/1", r2, c2);
        end
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: got ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic saw_done;
        @(negedge clk);
        Mode = 1'b0; A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({ready, busy, done, B_C} !== 4'b1000 || D_S !== 16'h0000) begin
            bad++;
            $display("FAIL reset_async: got rdy/busy/done/bc=%b D_S=%h want 1000/0000",
                     {ready, busy, done, B_C}, D_S);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++; $display("FAIL reset_no_done: got done pulse=%b want 0", saw_done);
        end
        do_op(1'b1, 16'h0005, 16'h0003, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h0002 || B_C !== 1'b1) begin
            bad++; $display("FAIL reset_recover: got lat=%0d %h/%b want 4 0002/1", lat, D_S, B_C);
        end
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_ovf();
        int lat;
        do_op(1'b0, 16'h7FFF, 16'h0001, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h8000 || OVF !== 1'b1 || B_C !== 1'b0) begin
            bad++; $display("FAIL ovf_add: got %h ovf=%b bc=%b want 8000/1/0", D_S, OVF, B_C);
        end
        do_op(1'b1, 16'h8000, 16'h0001, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h7FFF || OVF !== 1'b1) begin
            bad++; $display("FAIL ovf_sub: got %h ovf=%b want 7FFF/1", D_S, OVF);
        end
        do_op(1'b1, 16'h0005, 16'h0003, lat);
        total++;
        if (lat !== 4 || D_S !== 16'h0002 || OVF !== 1'b0) begin
            bad++; $display("FAIL ovf_none: got %h ovf=%b want 0002/0", D_S, OVF);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef OVERFLOW_FLAG_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
